// File: rtl/mem_port_arbiter_if.sv
// Pipeline-to-memory bundle shared by the IF/MEM requesters and the memory port.
// slave = arbiter view, master = pipeline plus memory model view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [31:0]           if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [2:0]            dm_width;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_width;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  if_stall;
  logic                  mem_stall;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_width,
    input  mem_ack, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    output if_stall, mem_stall
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_width,
    output mem_ack, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    input  if_stall, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates IF fetch vs MEM load/store onto one memory port, one transaction in flight; ARB_STARVE_GUARD_EN adds fetch anti-starvation.
// Latency: gnt in IDLE cycle N, mem_req from N+1, rvalid passes mem_rvalid through combinationally (N+1 earliest).
// Backpressure: requests wait (stall high) until IDLE grants them; mem_req holds until mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            width;
  } txn_t;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  txn_t   txn_q, txn_d;

  logic grant_if;
  logic grant_dm;
  logic complete;
  logic issue;
  logic fetch_priority;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  assign fetch_priority = bus.if_req && (starve_cnt_q == CntW'(STARVE_MAX));

  // Only dm grants that actually bypassed a waiting fetch count towards starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_dm) begin
      if (!bus.if_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != CntW'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign fetch_priority = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    txn_d    = txn_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    complete = 1'b0;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst) begin
          if (bus.dm_req && !fetch_priority) begin
            grant_dm    = 1'b1;
            txn_d.we    = bus.dm_we;
            txn_d.addr  = bus.dm_addr;
            txn_d.wdata = bus.dm_wdata;
            txn_d.width = bus.dm_width;
            owner_d     = OWN_DM;
            state_d     = ST_ISSUE;
          end else if (bus.if_req) begin
            grant_if    = 1'b1;
            txn_d.we    = 1'b0;
            txn_d.addr  = bus.if_addr;
            txn_d.wdata = '0;
            txn_d.width = 3'b010;
            owner_d     = OWN_IF;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (bus.mem_ack) begin
          if (bus.mem_rvalid) begin
            complete = 1'b1;
            owner_d  = OWN_NONE;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          complete = 1'b1;
          owner_d  = OWN_NONE;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      txn_q   <= txn_d;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;

  assign bus.mem_req   = issue;
  assign bus.mem_we    = txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;
  assign bus.mem_width = txn_q.width;

  // Completion is routed only to the requester that owns the transaction.
  assign bus.if_rvalid = complete && (owner_q == OWN_IF);
  assign bus.dm_rvalid = complete && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata[31:0] : 32'd0;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;

  assign bus.if_stall  = bus.if_req && !bus.if_rvalid;
  assign bus.mem_stall = bus.dm_req && !bus.dm_rvalid;

  cfg_starve_max_a: assert property (@(posedge clk) STARVE_MAX > 0);
  one_rvalid_a: assert property (@(posedge clk) disable iff (rst) !(bus.if_rvalid && bus.dm_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, store, fast completion, reset abort, starvation guard.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.dm_width   = 3'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    logic exp_if;
    quiet();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_width", 64'(bus.mem_width), 64'd0);
    chk("rst_gnts", 64'({bus.if_gnt, bus.dm_gnt}), 64'd0);
    tick();
    rst = 1'b0;

    // Single fetch: ack one cycle after gnt, rvalid two cycles after ack.
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    #2;
    chk("f_if_gnt", 64'(bus.if_gnt), 64'd1);
    chk("f_dm_gnt", 64'(bus.dm_gnt), 64'd0);
    chk("f_if_stall", 64'(bus.if_stall), 64'd1);
    tick();
    bus.mem_ack = 1'b1;
    #2;
    chk("f_mem_req", 64'(bus.mem_req), 64'd1);
    chk("f_mem_addr", 64'(bus.mem_addr), 64'h100);
    chk("f_mem_we", 64'(bus.mem_we), 64'd0);
    chk("f_mem_width", 64'(bus.mem_width), 64'd2);
    chk("f_gnt_busy", 64'(bus.if_gnt), 64'd0);
    tick();
    bus.mem_ack = 1'b0;
    #2;
    chk("f_wait_req", 64'(bus.mem_req), 64'd0);
    chk("f_wait_rv", 64'(bus.if_rvalid), 64'd0);
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h00500093;
    #2;
    chk("f_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("f_if_rdata", 64'(bus.if_rdata), 64'h00500093);
    chk("f_if_stall_done", 64'(bus.if_stall), 64'd0);
    chk("f_dm_rvalid", 64'(bus.dm_rvalid), 64'd0);
    tick();
    quiet();
    #2;
    chk("f_if_rdata_idle", 64'(bus.if_rdata), 64'd0);
    chk("f_stall_after", 64'(bus.if_stall), 64'd0);

    // Simultaneous requests: data wins, fetch follows after the IDLE bubble.
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
    #2;
    chk("s_dm_gnt", 64'(bus.dm_gnt), 64'd1);
    chk("s_if_gnt", 64'(bus.if_gnt), 64'd0);
    chk("s_stalls", 64'({bus.if_stall, bus.mem_stall}), 64'd3);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h11223344_55667788;
    #2;
    chk("s_mem_addr", 64'(bus.mem_addr), 64'h2000);
    chk("s_dm_rvalid", 64'(bus.dm_rvalid), 64'd1);
    chk("s_dm_rdata", bus.dm_rdata, 64'h11223344_55667788);
    chk("s_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    chk("s_mem_stall", 64'(bus.mem_stall), 64'd0);
    tick();
    bus.dm_req = 1'b0; bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
    #2;
    chk("s_if_gnt2", 64'(bus.if_gnt), 64'd1);
    chk("s_bubble_req", 64'(bus.mem_req), 64'd0);
    tick();
    bus.mem_ack = 1'b1;
    #2;
    chk("s_mem_addr2", 64'(bus.mem_addr), 64'h104);
    chk("s_mem_req2", 64'(bus.mem_req), 64'd1);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hAAAABBBB_00000013;
    #2;
    chk("s_if_rdata", 64'(bus.if_rdata), 64'h13);
    tick();
    quiet();

    // Store with stray ack/rvalid in IDLE first, which must be ignored.
    bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1;
    #2;
    chk("i_ignore_rv", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
    tick();
    quiet();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2008;
    bus.dm_wdata = 64'hDEADBEEF_CAFEF00D; bus.dm_width = 3'd3;
    #2;
    chk("w_dm_gnt", 64'(bus.dm_gnt), 64'd1);
    tick();
    bus.mem_ack = 1'b1;
    #2;
    chk("w_mem_we", 64'(bus.mem_we), 64'd1);
    chk("w_mem_wdata", bus.mem_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("w_mem_width", 64'(bus.mem_width), 64'd3);
    chk("w_mem_addr", 64'(bus.mem_addr), 64'h2008);
    tick();
    bus.mem_ack = 1'b0;
    #2;
    chk("w_wait_rv", 64'(bus.dm_rvalid), 64'd0);
    tick();
    bus.mem_rvalid = 1'b1;
    #2;
    chk("w_dm_rvalid", 64'(bus.dm_rvalid), 64'd1);
    chk("w_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    tick();
    quiet();

    // Same-cycle ack+rvalid, then a back-to-back data request.
    bus.dm_req = 1'b1; bus.dm_addr = 32'h3000;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h5;
    #2;
    chk("b_dm_rvalid", 64'(bus.dm_rvalid), 64'd1);
    chk("b_no_gnt", 64'(bus.dm_gnt), 64'd0);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.dm_addr = 32'h3008;
    #2;
    chk("b_regnt", 64'(bus.dm_gnt), 64'd1);
    chk("b_rv_idle", 64'(bus.dm_rvalid), 64'd0);
    tick();
    bus.dm_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1;
    #2;
    chk("b_mem_addr", 64'(bus.mem_addr), 64'h3008);
    tick();
    quiet();

    // Reset abandons a transaction parked in WAIT.
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #2;
    rst = 1'b1; bus.if_req = 1'b0;
    #1;
    chk("r_mem_addr_rst", 64'(bus.mem_addr), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
    #2;
    chk("r_no_rv", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
    chk("r_outs", 64'({bus.mem_req, bus.mem_we, bus.mem_width}), 64'd0);
    chk("r_addr", 64'(bus.mem_addr), 64'd0);
    tick();
    quiet();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    #2;
    chk("r_if_gnt", 64'(bus.if_gnt), 64'd1);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1;
    #2;
    chk("r_mem_addr", 64'(bus.mem_addr), 64'h300);
    chk("r_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    tick();
    quiet();

    // Fetch held while data keeps re-requesting.
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h4000;
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (k == 4);
`else
      exp_if = 1'b0;
`endif
      #2;
      chk("g_if_gnt", 64'(bus.if_gnt), 64'(exp_if));
      chk("g_dm_gnt", 64'(bus.dm_gnt), 64'(!exp_if));
      tick();
      bus.mem_ack = 1'b1; bus.mem_rvalid = 1'b1;
      #2;
      chk("g_if_rvalid", 64'(bus.if_rvalid), 64'(exp_if));
      tick();
      bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
    end
    quiet();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
